// File: rtl/mem_access_unit_pkg.sv
// mem_access_unit_pkg: MEM-stage state encoding and data-memory geometry, shared with hazard unit and memory model.
package mem_access_unit_pkg;
  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    ACCESS = 2'd1,
    RESP   = 2'd2
  } state_t;
  localparam int DMEM_DEPTH = 128;
  localparam int DATA_W = 16;
  function automatic logic legal_req(input logic ld, input logic st, input logic [15:0] addr, input int depth);
    return (ld ^ st) && ({1'b0, addr} < 17'(depth));
  endfunction
endpackage

// File: rtl/mem_access_unit_if.sv
// mem_access_unit_if: request, response and data-memory bus of the MEM-stage access unit.
interface mem_access_unit_if #(
  parameter int RD_W = 3
) ();
  logic            req_valid;
  logic            req_ready;
  logic            req_load;
  logic            req_store;
  logic [15:0]     req_addr;
  logic [15:0]     req_wdata;
  logic [RD_W-1:0] req_rd;
  logic            resp_valid;
  logic [15:0]     resp_data;
  logic [RD_W-1:0] resp_rd;
  logic            resp_fault;
  logic            stall;
  logic [15:0]     mem_addr;
  logic [15:0]     mem_wdata;
  logic            mem_write;
  logic            mem_load;
  logic [15:0]     mem_rdata;
  modport master (
    input  req_valid, req_load, req_store, req_addr, req_wdata, req_rd, mem_rdata,
    output req_ready, resp_valid, resp_data, resp_rd, resp_fault, stall,
           mem_addr, mem_wdata, mem_write, mem_load
  );
  modport slave (
    output req_valid, req_load, req_store, req_addr, req_wdata, req_rd, mem_rdata,
    input  req_ready, resp_valid, resp_data, resp_rd, resp_fault, stall,
           mem_addr, mem_wdata, mem_write, mem_load
  );
endinterface

// File: rtl/mem_access_unit.sv
// mem_access_unit: MEM-stage initiator holding memory strobes for WAIT_CYCLES+1 cycles, then a one-cycle response.
module mem_access_unit
  import mem_access_unit_pkg::*;
#(
  parameter int DEPTH       = DMEM_DEPTH,
  parameter int WAIT_CYCLES = 0,
  parameter int RD_W        = 3
) (
  input logic clk,
  input logic rst_n,
  mem_access_unit_if.master bus
);
  localparam logic [3:0] WAIT_INIT = 4'(WAIT_CYCLES);
  state_t          state_q, state_d;
  logic            is_load_q, is_load_d;
  logic            fault_q, fault_d;
  logic [3:0]      cnt_q, cnt_d;
  logic [15:0]     addr_q, addr_d;
  logic [15:0]     wdata_q, wdata_d;
  logic [15:0]     data_q, data_d;
  logic [RD_W-1:0] rd_q, rd_d;
  logic            legal;
  logic            idle, in_access, in_resp;
  assign legal = legal_req(bus.req_load, bus.req_store, bus.req_addr, DEPTH);
  always_comb begin
    state_d   = state_q;
    is_load_d = is_load_q;
    fault_d   = fault_q;
    cnt_d     = cnt_q;
    addr_d    = addr_q;
    wdata_d   = wdata_q;
    data_d    = data_q;
    rd_d      = rd_q;
    unique case (state_q)
      IDLE: if (bus.req_valid) begin
        state_d   = legal ? ACCESS : RESP;
        is_load_d = bus.req_load;
        fault_d   = !legal;
        cnt_d     = WAIT_INIT;
        addr_d    = bus.req_addr;
        wdata_d   = bus.req_wdata;
        rd_d      = bus.req_rd;
        data_d    = '0;
      end
      ACCESS: if (cnt_q == 4'd0) begin
        state_d = RESP;
        data_d  = is_load_q ? bus.mem_rdata : '0;
      end else begin
        cnt_d = cnt_q - 4'd1;
      end
      RESP:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= IDLE;
      is_load_q <= 1'b0;
      fault_q   <= 1'b0;
      cnt_q     <= '0;
      addr_q    <= '0;
      wdata_q   <= '0;
      data_q    <= '0;
      rd_q      <= '0;
    end else begin
      state_q   <= state_d;
      is_load_q <= is_load_d;
      fault_q   <= fault_d;
      cnt_q     <= cnt_d;
      addr_q    <= addr_d;
      wdata_q   <= wdata_d;
      data_q    <= data_d;
      rd_q      <= rd_d;
    end
  end
  assign idle      = state_q == IDLE;
  assign in_access = state_q == ACCESS;
  assign in_resp   = state_q == RESP;
  // Outputs decode straight from flops, so reset clears strobes and resp_valid asynchronously.
  assign bus.req_ready  = idle;
  assign bus.stall      = !idle || bus.req_valid;
  assign bus.mem_addr   = in_access ? addr_q : '0;
  assign bus.mem_wdata  = in_access ? wdata_q : '0;
  assign bus.mem_load   = in_access && is_load_q;
  assign bus.mem_write  = in_access && !is_load_q;
  assign bus.resp_valid = in_resp;
  assign bus.resp_data  = in_resp ? data_q : '0;
  assign bus.resp_rd    = in_resp ? rd_q : '0;
  assign bus.resp_fault = in_resp && fault_q;
endmodule

// File: tb/tb_mem_access_unit.sv
// tb_mem_access_unit: directed checks of two instances (WAIT_CYCLES 0 and 2) against a shared word memory model.
module tb_mem_access_unit;
  import mem_access_unit_pkg::*;
  logic clk = 1'b0;
  logic rst_n0 = 1'b0;
  logic rst_n2 = 1'b0;
  int tests = 0;
  int fails = 0;
  int strobes_a = 0;
  int resp_b = 0;
  int snap;
  logic [15:0] mem [0:DMEM_DEPTH-1];
  always #5 clk = ~clk;
  mem_access_unit_if #(.RD_W(3)) a ();
  mem_access_unit_if #(.RD_W(3)) b ();
  mem_access_unit #(.DEPTH(DMEM_DEPTH), .WAIT_CYCLES(0), .RD_W(3)) dut0 (.clk(clk), .rst_n(rst_n0), .bus(a.master));
  mem_access_unit #(.DEPTH(DMEM_DEPTH), .WAIT_CYCLES(2), .RD_W(3)) dut2 (.clk(clk), .rst_n(rst_n2), .bus(b.master));
  assign a.mem_rdata = a.mem_load ? mem[a.mem_addr[6:0]] : 16'h0;
  assign b.mem_rdata = b.mem_load ? mem[b.mem_addr[6:0]] : 16'h0;
  initial begin
    for (int i = 0; i < DMEM_DEPTH; i++) mem[i] <= 16'h0;
    mem[2] <= 16'hABFA;
    mem[5] <= 16'hBF5F;
  end
  always @(posedge clk) begin
    if (a.mem_write) mem[a.mem_addr[6:0]] <= a.mem_wdata;
    if (b.mem_write) mem[b.mem_addr[6:0]] <= b.mem_wdata;
    if (a.mem_load || a.mem_write) strobes_a <= strobes_a + 1;
    if (b.resp_valid) resp_b <= resp_b + 1;
  end
  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask
  task automatic tick();
    @(posedge clk);
    #1;
  endtask
  task automatic req_a(input logic v, input logic ld, input logic st, input logic [15:0] ad, input logic [15:0] wd, input logic [2:0] rd);
    a.req_valid = v; a.req_load = ld; a.req_store = st; a.req_addr = ad; a.req_wdata = wd; a.req_rd = rd;
    #1;
  endtask
  task automatic req_b(input logic v, input logic ld, input logic st, input logic [15:0] ad, input logic [15:0] wd, input logic [2:0] rd);
    b.req_valid = v; b.req_load = ld; b.req_store = st; b.req_addr = ad; b.req_wdata = wd; b.req_rd = rd;
    #1;
  endtask
  initial begin
    #100000;
    $display("FAIL timeout tests=%0d", tests);
    $fatal(1, "timeout");
  end
  initial begin
    req_a(0, 0, 0, 0, 0, 0);
    req_b(0, 0, 0, 0, 0, 0);
    #7;
    chk("rst_ready", a.req_ready, 1);
    chk("rst_resp_valid", a.resp_valid, 0);
    chk("rst_stall", a.stall, 0);
    chk("rst_strobes", {a.mem_load, a.mem_write, b.mem_load, b.mem_write}, 0);
    chk("rst_resp_data", a.resp_data, 0);
    chk("rst_b_ready", b.req_ready, 1);
    #4;
    rst_n0 = 1'b1;
    rst_n2 = 1'b1;
    // Test 1: WAIT=0 load of word 2
    tick();
    req_a(1, 1, 0, 16'd2, 16'h0, 3'd3);
    chk("t1_accept_stall", a.stall, 1);
    chk("t1_accept_ready", a.req_ready, 1);
    tick();
    req_a(0, 0, 0, 0, 0, 0);
    chk("t1_mem_load", a.mem_load, 1);
    chk("t1_mem_addr", a.mem_addr, 16'd2);
    chk("t1_mem_write", a.mem_write, 0);
    chk("t1_access_stall", a.stall, 1);
    chk("t1_access_ready", a.req_ready, 0);
    chk("t1_access_rv", a.resp_valid, 0);
    tick();
    chk("t1_resp_valid", a.resp_valid, 1);
    chk("t1_resp_data", a.resp_data, 16'hABFA);
    chk("t1_resp_rd", a.resp_rd, 3);
    chk("t1_resp_fault", a.resp_fault, 0);
    chk("t1_resp_load_off", a.mem_load, 0);
    tick();
    chk("t1_idle_rv", a.resp_valid, 0);
    chk("t1_idle_ready", a.req_ready, 1);
    chk("t1_idle_data", a.resp_data, 0);
    chk("t1_idle_stall", a.stall, 0);
    // Test 2: store then load back
    req_a(1, 0, 1, 16'd5, 16'h1234, 3'd2);
    tick();
    req_a(0, 0, 0, 0, 0, 0);
    chk("t2_mem_write", a.mem_write, 1);
    chk("t2_mem_load", a.mem_load, 0);
    chk("t2_mem_addr", a.mem_addr, 16'd5);
    chk("t2_mem_wdata", a.mem_wdata, 16'h1234);
    tick();
    chk("t2_st_resp_valid", a.resp_valid, 1);
    chk("t2_st_resp_data", a.resp_data, 0);
    chk("t2_st_write_off", a.mem_write, 0);
    tick();
    req_a(1, 1, 0, 16'd5, 16'h0, 3'd6);
    tick();
    req_a(0, 0, 0, 0, 0, 0);
    tick();
    chk("t2_ld_resp_valid", a.resp_valid, 1);
    chk("t2_ld_resp_data", a.resp_data, 16'h1234);
    chk("t2_ld_resp_rd", a.resp_rd, 6);
    tick();
    // Test 4: faults never strobe
    snap = strobes_a;
    req_a(1, 1, 0, 16'd128, 16'h0, 3'd5);
    tick();
    req_a(0, 0, 0, 0, 0, 0);
    chk("t4_a128_rv", a.resp_valid, 1);
    chk("t4_a128_fault", a.resp_fault, 1);
    chk("t4_a128_data", a.resp_data, 0);
    chk("t4_a128_rd", a.resp_rd, 5);
    chk("t4_a128_ready", a.req_ready, 0);
    tick();
    chk("t4_a128_idle_rv", a.resp_valid, 0);
    req_a(1, 1, 1, 16'd2, 16'h9999, 3'd4);
    tick();
    req_a(0, 0, 0, 0, 0, 0);
    chk("t4_both_rv", a.resp_valid, 1);
    chk("t4_both_fault", a.resp_fault, 1);
    chk("t4_both_data", a.resp_data, 0);
    tick();
    req_a(1, 0, 0, 16'd2, 16'h0, 3'd1);
    tick();
    req_a(0, 0, 0, 0, 0, 0);
    chk("t4_none_fault", a.resp_fault, 1);
    tick();
    req_a(1, 1, 0, 16'hFFFF, 16'h0, 3'd1);
    tick();
    req_a(0, 0, 0, 0, 0, 0);
    chk("t4_ffff_fault", a.resp_fault, 1);
    tick();
    chk("t4_no_strobes", strobes_a, snap);
    req_a(1, 1, 0, 16'd127, 16'h0, 3'd7);
    tick();
    req_a(0, 0, 0, 0, 0, 0);
    chk("t4_a127_load", a.mem_load, 1);
    chk("t4_a127_addr", a.mem_addr, 16'd127);
    tick();
    chk("t4_a127_rv", a.resp_valid, 1);
    chk("t4_a127_fault", a.resp_fault, 0);
    chk("t4_a127_rd", a.resp_rd, 7);
    tick();
    // Tests 3 and 6: WAIT=2 load, request inputs change mid-access
    req_b(1, 1, 0, 16'd2, 16'h0, 3'd1);
    chk("t3_accept_stall", b.stall, 1);
    tick();
    req_b(1, 0, 1, 16'd7, 16'hDEAD, 3'd6);
    for (int c = 1; c <= 3; c++) begin
      chk($sformatf("t3_c%0d_load", c), b.mem_load, 1);
      chk($sformatf("t3_c%0d_write", c), b.mem_write, 0);
      chk($sformatf("t3_c%0d_addr", c), b.mem_addr, 16'd2);
      chk($sformatf("t3_c%0d_wdata", c), b.mem_wdata, 16'h0);
      chk($sformatf("t3_c%0d_stall", c), b.stall, 1);
      chk($sformatf("t3_c%0d_ready", c), b.req_ready, 0);
      chk($sformatf("t3_c%0d_rv", c), b.resp_valid, 0);
      if (c == 3) req_b(0, 0, 0, 0, 0, 0);
      tick();
    end
    chk("t3_resp_valid", b.resp_valid, 1);
    chk("t3_resp_data", b.resp_data, 16'hABFA);
    chk("t3_resp_rd", b.resp_rd, 1);
    chk("t3_resp_fault", b.resp_fault, 0);
    chk("t3_resp_load_off", b.mem_load, 0);
    chk("t3_resp_ready", b.req_ready, 0);
    tick();
    chk("t3_idle_rv", b.resp_valid, 0);
    chk("t3_idle_ready", b.req_ready, 1);
    // Test 5: reset during second cycle of WAIT=2 store
    req_b(1, 0, 1, 16'd10, 16'h5555, 3'd2);
    tick();
    req_b(0, 0, 0, 0, 0, 0);
    chk("t5_c1_write", b.mem_write, 1);
    tick();
    chk("t5_c2_write", b.mem_write, 1);
    chk("t5_c2_addr", b.mem_addr, 16'd10);
    snap = resp_b;
    rst_n2 = 1'b0;
    #1;
    chk("t5_rst_write", b.mem_write, 0);
    chk("t5_rst_rv", b.resp_valid, 0);
    chk("t5_rst_stall", b.stall, 0);
    tick();
    tick();
    rst_n2 = 1'b1;
    tick();
    tick();
    chk("t5_no_resp", resp_b, snap);
    chk("t5_ready", b.req_ready, 1);
    chk("t5_outs", {b.mem_addr, b.mem_wdata}, 0);
    chk("t5_resp_outs", {b.resp_data, 13'h0, b.resp_rd}, 0);
    chk("t5_flags", {b.resp_fault, b.mem_load, b.mem_write, b.stall, b.resp_valid}, 0);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
